// File: rtl/sd_arb_pkg.sv
// Shared types and helpers for the SD host-channel port arbiter and
// the other shared-resource arbiters that reuse its round-robin picker.
package sd_arb_pkg;

    // Arbiter sequencing: guard against a stale ack, pick, request, transfer, release.
    typedef enum logic [2:0] {
        SYNC = 3'd0,
        IDLE = 3'd1,
        REQ  = 3'd2,
        XFER = 3'd3,
        REL  = 3'd4
    } arb_state_e;

    // Direction of the latched host transaction.
    typedef enum logic {
        RD = 1'b0,
        WR = 1'b1
    } arb_op_e;

    localparam int SECTOR_BYTES = 512;

    // Index width for n requesters; a single requester still gets one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Successor of idx in a ring of n requesters.
    function automatic int wrap_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/sd_port_arbiter_rr_pick.sv
// Round-robin picker: first set bit of pend searching upward from ptr,
// wrapping around. Purely combinational.
module sd_port_arbiter_rr_pick
    import sd_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  pend,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] cand_s [N];
    logic          hit_s;

    // Requester numbers in visiting order, starting at ptr.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            cand_s[k] = IW'((int'(ptr) + k) % N);
        end
    end

    // The first pending candidate in visiting order wins; later hits are masked.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        hit_s = 1'b0;
        for (int k = 0; k < N; k++) begin
            hit_s = pend[cand_s[k]] & ~valid;
            idx   = hit_s ? cand_s[k] : idx;
            valid = valid | hit_s;
        end
    end

endmodule

// File: rtl/sd_port_arbiter.sv
// Shares one host block-device channel between N drive units.
// One sector transaction at a time, round-robin grant held until the
// host ack falls, with a request watchdog against a dead host.
module sd_port_arbiter
    import sd_arb_pkg::*;
#(
    parameter int N     = 2,
    parameter int TMO_W = 24
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [32*N-1:0]   req_lba,
    input  logic [N-1:0]      req_rd,
    input  logic [N-1:0]      req_wr,
    output logic [N-1:0]      req_ack,
    input  logic [8*N-1:0]    req_buff_din,
    output logic [N-1:0]      req_buff_wr,
    output logic [N-1:0]      req_err,
    output logic [31:0]       sd_lba,
    output logic              sd_rd,
    output logic              sd_wr,
    input  logic              sd_ack,
    input  logic [8:0]        sd_buff_addr,
    input  logic [7:0]        sd_buff_dout,
    output logic [7:0]        sd_buff_din,
    input  logic              sd_buff_wr
);

    localparam int IW   = idx_w(N);
    localparam int WD_W = (TMO_W > 0) ? TMO_W : 1;
    localparam logic [WD_W-1:0] WD_MAX = {WD_W{1'b1}};
    localparam logic [WD_W-1:0] WD_ONE = WD_W'(1);

    arb_state_e    state_q,  state_d;
    arb_op_e       op_q,     op_d;
    logic [IW-1:0] grant_q,  grant_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [31:0]   lba_q,    lba_d;
    logic [WD_W-1:0] wd_q,   wd_d;
    logic          sd_rd_q,  sd_rd_d;
    logic          sd_wr_q,  sd_wr_d;
    logic [N-1:0]  req_err_q, req_err_d;

    logic [N-1:0]  pend_s;
    logic          pick_valid_s;
    logic [IW-1:0] pick_idx_s;
    logic          timeout_s;
    logic [N-1:0]  req_ack_s;
    logic [N-1:0]  req_buff_wr_s;
    logic [31:0]   lba_arr_s [N];
    logic [7:0]    din_arr_s [N];

    // Host buffer address and read data reach the requesters outside this
    // block; they are folded here only so the ports have a load.
    logic buff_unused_s;
    assign buff_unused_s = ^{sd_buff_addr, sd_buff_dout};

    assign pend_s = req_rd | req_wr;

    sd_port_arbiter_rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_rr_pick (
        .pend  (pend_s),
        .ptr   (rr_ptr_q),
        .valid (pick_valid_s),
        .idx   (pick_idx_s)
    );

    // Split the flat per-requester buses into indexable arrays.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            lba_arr_s[i] = req_lba[32*i +: 32];
            din_arr_s[i] = req_buff_din[8*i +: 8];
        end
    end

    // Watchdog terminal count; a zero width turns the watchdog off.
    assign timeout_s = (TMO_W > 0) ? (wd_q == WD_MAX) : 1'b0;

    // Next-state logic and registered host-request / error outputs.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        lba_d     = lba_q;
        wd_d      = wd_q;
        sd_rd_d   = 1'b0;
        sd_wr_d   = 1'b0;
        req_err_d = '0;
        case (state_q)
            SYNC: begin
                // An ack still high after reset belongs to a transaction we no longer own.
                if (!sd_ack) begin
                    state_d = IDLE;
                end else begin
                    state_d = SYNC;
                end
            end
            IDLE: begin
                if (pick_valid_s) begin
                    grant_d = pick_idx_s;
                    lba_d   = lba_arr_s[pick_idx_s];
                    op_d    = req_wr[pick_idx_s] ? WR : RD;
                    wd_d    = '0;
                    state_d = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                // Ack wins over a same-cycle timeout: the host did answer.
                if (sd_ack) begin
                    state_d = XFER;
                end else if (timeout_s) begin
                    req_err_d[grant_q] = 1'b1;
                    state_d            = REL;
                end else begin
                    sd_rd_d = (op_q == RD);
                    sd_wr_d = (op_q == WR);
                    wd_d    = wd_q + WD_ONE;
                end
            end
            XFER: begin
                if (!sd_ack) begin
                    state_d = REL;
                end else begin
                    state_d = XFER;
                end
            end
            REL: begin
                rr_ptr_d = IW'(wrap_next(int'(grant_q), N));
                state_d  = IDLE;
            end
            default: begin
                state_d = SYNC;
            end
        endcase
    end

    // State and latched-transaction registers; reset clears everything and re-enters SYNC.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q   <= SYNC;
            op_q      <= RD;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            lba_q     <= 32'h0000_0000;
            wd_q      <= '0;
            sd_rd_q   <= 1'b0;
            sd_wr_q   <= 1'b0;
            req_err_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            lba_q     <= lba_d;
            wd_q      <= wd_d;
            sd_rd_q   <= sd_rd_d;
            sd_wr_q   <= sd_wr_d;
            req_err_q <= req_err_d;
        end
    end

    // Ack and buffer strobe pass straight through to the granted requester during a transfer only.
    always_comb begin
        req_ack_s     = '0;
        req_buff_wr_s = '0;
        if (state_q == XFER) begin
            req_ack_s[grant_q]     = sd_ack;
            req_buff_wr_s[grant_q] = sd_buff_wr;
        end else begin
            req_ack_s     = '0;
            req_buff_wr_s = '0;
        end
    end

    assign req_ack     = req_ack_s;
    assign req_buff_wr = req_buff_wr_s;
    assign req_err     = req_err_q;
    assign sd_lba      = lba_q;
    assign sd_rd       = sd_rd_q;
    assign sd_wr       = sd_wr_q;
    assign sd_buff_din = din_arr_s[grant_q];

endmodule

// File: tb/tb_sd_port_arbiter.sv
// Self-checking bench for sd_port_arbiter (N=2, 4-bit watchdog).
module tb_sd_port_arbiter;
    import sd_arb_pkg::*;

    localparam int N   = 2;
    localparam int TMO = 4;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [63:0] req_lba;
    logic [1:0]  req_rd, req_wr, req_ack, req_buff_wr, req_err;
    logic [15:0] req_buff_din;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, sd_ack, sd_buff_wr;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout, sd_buff_din;

    int checks   = 0;
    int failures = 0;

    always #5 clk_sys = ~clk_sys;

    sd_port_arbiter #(.N(N), .TMO_W(TMO)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .req_lba      (req_lba),
        .req_rd       (req_rd),
        .req_wr       (req_wr),
        .req_ack      (req_ack),
        .req_buff_din (req_buff_din),
        .req_buff_wr  (req_buff_wr),
        .req_err      (req_err),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_addr (sd_buff_addr),
        .sd_buff_dout (sd_buff_dout),
        .sd_buff_din  (sd_buff_din),
        .sd_buff_wr   (sd_buff_wr)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // m_blocked: stale host ack must fall first; m_busy: a requester owns the channel;
    // m_xfer: host has acked; m_cool: one dead cycle after the owner finishes;
    // m_age: cycles the host request has been outstanding.
    bit          m_blocked, m_busy, m_xfer, m_cool, m_host, m_wr;
    int          m_ptr, m_grant, m_age, m_i;
    logic [31:0] m_lba;
    logic [1:0]  m_err;

    always begin
        @(posedge clk_sys);
        m_err  = 2'b00;
        m_host = 1'b0;
        if (reset) begin
            m_blocked = 1'b1; m_busy = 1'b0; m_xfer = 1'b0; m_cool = 1'b0;
            m_ptr = 0; m_grant = 0; m_age = 0; m_wr = 1'b0; m_lba = 32'h0;
        end else if (m_blocked) begin
            if (!sd_ack) m_blocked = 1'b0;
        end else if (m_cool) begin
            m_cool = 1'b0;
            m_busy = 1'b0;
            m_ptr  = (m_grant + 1) % N;
        end else if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                m_i = (m_ptr + k) % N;
                if (!m_busy && (req_rd[m_i] || req_wr[m_i])) begin
                    m_busy  = 1'b1;
                    m_grant = m_i;
                    m_lba   = req_lba[32*m_i +: 32];
                    m_wr    = req_wr[m_i];
                    m_age   = 0;
                end
            end
        end else if (m_xfer) begin
            if (!sd_ack) begin m_xfer = 1'b0; m_cool = 1'b1; end
        end else if (sd_ack) begin
            m_xfer = 1'b1;
        end else if (m_age == (1 << TMO) - 1) begin
            m_err[m_grant] = 1'b1;
            m_cool = 1'b1;
        end else begin
            m_age++;
            m_host = 1'b1;
        end
        #2;
        chk("sd_rd",       sd_rd,       m_host && !m_wr);
        chk("sd_wr",       sd_wr,       m_host && m_wr);
        chk("sd_lba",      sd_lba,      m_lba);
        chk("req_ack",     req_ack,     m_xfer ? ((2'b01 << m_grant) & {2{sd_ack}}) : 2'b00);
        chk("req_buff_wr", req_buff_wr, m_xfer ? ((2'b01 << m_grant) & {2{sd_buff_wr}}) : 2'b00);
        chk("req_err",     req_err,     m_err);
        chk("sd_buff_din", sd_buff_din, req_buff_din[8*m_grant +: 8]);
    end

    // ---------------- host emulation ----------------
    // Wait for a host request, ack after delay cycles, stream len bytes, drop ack.
    task automatic do_txn(input int delay, input int len, input logic [1:0] drop,
                          output logic [1:0] ack_seen, output logic [1:0] op_seen,
                          output logic [7:0] din_seen, output int bw0, output int bw1);
        bit ok = 1'b0;
        ack_seen = 2'b00; op_seen = 2'b00; din_seen = 8'h00; bw0 = 0; bw1 = 0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk_sys);
            if (sd_rd || sd_wr) ok = 1'b1;
        end
        chk("host_req_seen", {63'd0, ok}, 64'd1);
        if (!ok) return;
        op_seen = {sd_wr, sd_rd};
        repeat (delay) @(negedge clk_sys);
        sd_ack = 1'b1;
        req_rd = req_rd & ~drop;
        req_wr = req_wr & ~drop;
        for (int i = 0; i < len; i++) begin
            @(negedge clk_sys);
            sd_buff_wr   = i[0];
            sd_buff_addr = i[8:0];
            sd_buff_dout = i[7:0];
            #1;
            if (i == 0) begin ack_seen = req_ack; din_seen = sd_buff_din; end
            if (req_buff_wr[0]) bw0++;
            if (req_buff_wr[1]) bw1++;
        end
        @(negedge clk_sys);
        sd_buff_wr = 1'b0;
        sd_ack     = 1'b0;
    endtask

    logic [1:0] a_s, o_s, err_v;
    logic [7:0] d_s;
    int         b0, b1, n_hi;
    bit         got, rd_at_err;

    initial begin
        reset = 1'b1;
        req_lba = {32'h0000_0200, 32'h0000_0000};
        req_rd = 2'b00; req_wr = 2'b00;
        req_buff_din = {8'h5A, 8'h3C};
        sd_ack = 1'b0; sd_buff_wr = 1'b0; sd_buff_addr = 9'd0; sd_buff_dout = 8'd0;

        // Reset state
        @(posedge clk_sys); #2;
        chk("rst_sd_rd", sd_rd, 1'b0);
        chk("rst_sd_lba", sd_lba, 32'h0);
        chk("rst_req_ack", req_ack, 2'b00);
        chk("rst_req_err", req_err, 2'b00);
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
        repeat (2) @(negedge clk_sys);

        // Single read from requester 0, full sector, 2-cycle request latency
        req_lba[31:0] = 32'h0000_0165;
        req_rd = 2'b01;
        @(posedge clk_sys); #2;
        chk("t1_rd_lat1", sd_rd, 1'b0);
        @(posedge clk_sys); #2;
        chk("t1_rd_lat2", sd_rd, 1'b1);
        chk("t1_lba", sd_lba, 32'h0000_0165);
        do_txn(5, SECTOR_BYTES, 2'b01, a_s, o_s, d_s, b0, b1);
        chk("t1_ack", a_s, 2'b01);
        chk("t1_op", o_s, 2'b01);
        chk("t1_bw0", b0, 256);
        chk("t1_bw1", b1, 0);

        // Write data path from requester 1 (pointer now at 1)
        req_buff_din = {8'hA5, 8'h3C};
        req_lba[63:32] = 32'h0000_0777;
        req_wr = 2'b10;
        do_txn(2, 8, 2'b10, a_s, o_s, d_s, b0, b1);
        chk("t2_ack", a_s, 2'b10);
        chk("t2_op", o_s, 2'b10);
        chk("t2_din", d_s, 8'hA5);
        chk("t2_bw1", b1, 4);
        chk("t2_bw0", b0, 0);

        // Contention: rd on 0, wr on 1, held continuously; grants alternate 0,1,0,1
        req_rd = 2'b01; req_wr = 2'b10;
        for (int k = 0; k < 4; k++) begin
            do_txn(1, 4, (k == 3) ? 2'b11 : 2'b00, a_s, o_s, d_s, b0, b1);
            chk("t3_grant", a_s, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk("t3_op", o_s, (k % 2 == 0) ? 2'b01 : 2'b10);
        end

        // Timeout: both read, host silent for requester 0; counter hits 15
        req_lba[31:0] = 32'h0000_0ABC;
        req_rd = 2'b11;
        n_hi = 0; got = 1'b0; err_v = 2'b00; rd_at_err = 1'b0;
        for (int t = 0; t < 40 && !got; t++) begin
            @(posedge clk_sys); #2;
            if (req_err != 2'b00) begin
                got = 1'b1; err_v = req_err; rd_at_err = sd_rd;
            end else if (sd_rd) begin
                n_hi++;
            end
        end
        chk("t4_err_seen", {63'd0, got}, 64'd1);
        chk("t4_err_bits", err_v, 2'b01);
        chk("t4_rd_cycles", n_hi, 15);
        chk("t4_rd_drop", rd_at_err, 1'b0);
        @(posedge clk_sys); #2;
        chk("t4_err_once", req_err, 2'b00);
        @(negedge clk_sys);
        req_rd = 2'b10;
        do_txn(1, 4, 2'b10, a_s, o_s, d_s, b0, b1);
        chk("t4_next_grant", a_s, 2'b10);

        // Read and write together on requester 0: write wins
        req_rd = 2'b01; req_wr = 2'b01;
        do_txn(1, 4, 2'b01, a_s, o_s, d_s, b0, b1);
        chk("t5_op", o_s, 2'b10);
        chk("t5_ack", a_s, 2'b01);

        // Reset in the middle of requester 1's transfer (pointer at 1)
        req_rd = 2'b10;
        got = 1'b0;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk_sys);
            if (sd_rd) got = 1'b1;
        end
        chk("t6_req_seen", {63'd0, got}, 64'd1);
        sd_ack = 1'b1; sd_buff_wr = 1'b1; req_rd = 2'b11;
        repeat (2) @(negedge clk_sys);
        #1;
        chk("t6_ack_before", req_ack, 2'b10);
        reset = 1'b1;
        @(posedge clk_sys); #2;
        chk("t6_ack_zero", req_ack, 2'b00);
        chk("t6_bw_zero", req_buff_wr, 2'b00);
        chk("t6_rdwr_zero", {sd_rd, sd_wr}, 2'b00);
        chk("t6_lba_zero", sd_lba, 32'h0);
        @(negedge clk_sys);
        reset = 1'b0;
        for (int t = 0; t < 4; t++) begin
            @(posedge clk_sys); #2;
            chk("t6_sync_hold", {sd_rd, sd_wr}, 2'b00);
        end
        @(negedge clk_sys);
        sd_ack = 1'b0; sd_buff_wr = 1'b0;
        do_txn(1, 4, 2'b11, a_s, o_s, d_s, b0, b1);
        chk("t6_grant_after_rst", a_s, 2'b01);

        repeat (4) @(negedge clk_sys);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sd_port_arbiter.md
Name: sd_port_arbiter

Overview:
- Shares one host block-device channel (sd_lba/sd_rd/sd_wr/sd_ack/sd_buff_*) between N drive units, e.g. the drive-8 and drive-9 selector instances.
- Round-robin grant, one 512-byte sector transaction at a time. The grant is held until the host ack falls.
- Sits between the drive selectors and the host I/O channel, in the clk_sys domain.
- Includes a request watchdog so a dead host cannot lock out requesters.

Parameters:
- N, 2: number of requesters, 2..4.
- TMO_W, 24: width of the watchdog counter. A timeout fires when the counter reaches all-ones. 0 disables the watchdog.

Ports:
- clk_sys  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high.
- req_lba  in  32*N  per-requester LBA; slice i is requester i.
- req_rd  in  N  per-requester read request, level; held until its ack rises.
- req_wr  in  N  per-requester write request, level.
- req_ack  out  N  per-requester ack; only the granted bit may be high.
- req_buff_din  in  8*N  per-requester write data for the host.
- req_buff_wr  out  N  per-requester buffer write strobe.
- req_err  out  N  one-cycle pulse when requester i's request times out.
- sd_lba  out  32  host LBA.
- sd_rd  out  1  host read request.
- sd_wr  out  1  host write request.
- sd_ack  in  1  host ack.
- sd_buff_addr  in  9  host buffer address; broadcast to all requesters externally.
- sd_buff_dout  in  8  host read data; broadcast to all requesters externally.
- sd_buff_din  out  8  mux of req_buff_din[grant].
- sd_buff_wr  in  1  host buffer write strobe.

Behaviour:
- Reset values: sd_rd=0, sd_wr=0, sd_lba=0, req_ack=0, req_buff_wr=0, req_err=0, grant=0, rr_ptr=0, state=SYNC.
- Reset mid-transaction: all outputs drop in the cycle after reset is sampled. No queued state survives.

States:
- SYNC: wait until sd_ack=0, then go to IDLE. This avoids adopting a stale ack after reset.
- IDLE:
  - Pending set P = req_rd | req_wr.
  - Choose the first set bit of P searching from rr_ptr upward, with wrap-around.
  - Latch grant=i, lba=req_lba[i], op=WR if req_wr[i] else RD. Write has priority when both are set.
  - Go to REQ in the next cycle. No request: stay.
- REQ:
  - sd_rd/sd_wr driven from the latched op, sd_lba from the latched lba.
  - Outputs stay latched even if the requester drops its request.
  - sd_ack=1: go to XFER; host request deasserts in that same cycle.
  - Watchdog reaches terminal count: pulse req_err[grant] for 1 cycle, drop the host request, go to REL.
- XFER:
  - req_ack[grant]=sd_ack.
  - req_buff_wr[grant]=sd_buff_wr; all other bits 0.
  - sd_buff_din=req_buff_din[grant].
  - sd_ack falls: go to REL.
- REL: rr_ptr=(grant+1) mod N, then IDLE. One dead cycle so the requester can sample the ack fall.

Latencies:
- Request to host sd_rd/sd_wr: 2 cycles (IDLE latch, then REQ register).
- Host ack to requester ack: combinational pass-through in XFER.

Watchdog:
- Counter is cleared on entry to REQ and increments only in REQ.
- Never active in XFER, since transfer length is host-defined.

Fairness and boundaries:
- Worst-case wait is N-1 transactions.
- Requests arriving during REQ/XFER/REL are not lost; they are level-held and seen in IDLE.
- Ungranted requesters never see ack or buff_wr.
- sd_buff_din defaults to req_buff_din[grant] in all states.
- N=1 degenerates to a registered pass-through.

Decomposition:
- Shared package sd_arb_pkg holds:
  - state enum: SYNC, IDLE, REQ, XFER, REL;
  - op enum: RD, WR;
  - SECTOR_BYTES=512.
- Sub-module rr_pick: combinational rotate/priority-encode of P from rr_ptr to {valid, index}. Reused by the other shared-resource arbiters.

Test Plan:
- Single read:
  - Stimulus: req_rd[0]=1, req_lba[0]=0x00000165; host asserts ack 5 cycles after sd_rd, holds 512 cycles, then drops.
  - Required: sd_rd=1 two cycles after request with sd_lba=0x165; req_ack[0] mirrors ack; req_ack[1]=0.
- Contention:
  - Stimulus: req_rd[0] and req_wr[1] both asserted continuously, N=2.
  - Required: grants alternate 0,1,0,1; sd_wr=1 only during requester 1 turns.
- Write data path:
  - Stimulus: requester 1 presents req_buff_din=0xA5 during XFER with sd_buff_wr pulses.
  - Required: sd_buff_din=0xA5; req_buff_wr[1] pulses match sd_buff_wr; req_buff_wr[0]=0.
- Timeout:
  - Stimulus: TMO_W=4, requester 0 reads, host never acks.
  - Required: req_err[0] pulses once when the counter reaches 15; sd_rd drops; the next pending requester is served.
- Reset mid-XFER:
  - Stimulus: reset asserted while sd_ack=1.
  - Required: all outputs 0 the next cycle; FSM stays in SYNC until sd_ack=0; the next grant goes to requester 0.
- Rd+wr together:
  - Stimulus: req_rd[0]=req_wr[0]=1.
  - Required: sd_wr asserted, sd_rd=0.
